// File: rtl/digit_serial_addsub.sv
// Digit-serial add/subtract unit.
// A WIDTH-bit add or subtract is evaluated DIGIT bits per cycle, LSB digit
// first, through one registered carry. Operands enter on a valid/ready
// handshake in IDLE; the result and flags leave on a valid/ready handshake
// in DONE. Subtraction is a + ~b + ~cin, so the final carry is "not borrow".
module digit_serial_addsub #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             zero,
  output logic             neg,
  output logic             ovf
);

  localparam int STEPS = WIDTH / DIGIT;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(STEPS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             sub_reg;
  logic             carry_reg;
  logic [CW-1:0]    step_reg;
  logic [WIDTH-1:0] acc_reg;
  logic [WIDTH-1:0] result_reg;
  logic             cout_reg;
  logic             zero_reg;
  logic             neg_reg;
  logic             ovf_reg;
  logic             in_ready_reg;
  logic             out_valid_reg;

  // Operand digits; the subtrahend is inverted here so the adder is shared.
  logic [DIGIT-1:0] a_dig [STEPS];
  logic [DIGIT-1:0] b_dig [STEPS];

  genvar gi;
  generate
    for (gi = 0; gi < STEPS; gi++) begin : g_digit
      assign a_dig[gi] = a_reg[gi*DIGIT +: DIGIT];
      assign b_dig[gi] = sub_reg ? ~b_reg[gi*DIGIT +: DIGIT]
                                 :  b_reg[gi*DIGIT +: DIGIT];
    end
  endgenerate

  logic [DIGIT-1:0] a_cur;
  logic [DIGIT-1:0] b_cur;
  logic [DIGIT:0]   sum_next;
  logic [DIGIT-1:0] digit_next;
  logic             carry_next;
  logic             msb_carry_in;
  logic [WIDTH-1:0] acc_next;
  logic             last_step;

  // Select the digit pair addressed by the step counter.
  always_comb begin
    a_cur = '0;
    b_cur = '0;
    for (int i = 0; i < STEPS; i++) begin
      if (step_reg == CW'(i)) begin
        a_cur = a_dig[i];
        b_cur = b_dig[i];
      end
    end
  end

  // One narrow adder step; the carry into the top bit of the digit is
  // recovered from the sum bit, which is only meaningful on the last step.
  always_comb begin
    sum_next     = {1'b0, a_cur} + {1'b0, b_cur} + {{DIGIT{1'b0}}, carry_reg};
    digit_next   = sum_next[DIGIT-1:0];
    carry_next   = sum_next[DIGIT];
    msb_carry_in = a_cur[DIGIT-1] ^ b_cur[DIGIT-1] ^ digit_next[DIGIT-1];
    last_step    = (step_reg == LAST_STEP);
  end

  // Accumulator with the current digit merged in at its bit position.
  always_comb begin
    acc_next = acc_reg;
    for (int i = 0; i < STEPS; i++) begin
      if (step_reg == CW'(i)) begin
        acc_next[i*DIGIT +: DIGIT] = digit_next;
      end
    end
  end

  // Control FSM plus datapath registers; results only change on RUN->DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      a_reg         <= '0;
      b_reg         <= '0;
      sub_reg       <= 1'b0;
      carry_reg     <= 1'b0;
      step_reg      <= '0;
      acc_reg       <= '0;
      result_reg    <= '0;
      cout_reg      <= 1'b0;
      zero_reg      <= 1'b0;
      neg_reg       <= 1'b0;
      ovf_reg       <= 1'b0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            a_reg        <= a;
            b_reg        <= b;
            sub_reg      <= sub;
            carry_reg    <= sub ? ~cin : cin;
            step_reg     <= '0;
            state_reg    <= RUN;
            in_ready_reg <= 1'b0;
          end
        end
        RUN: begin
          acc_reg   <= acc_next;
          carry_reg <= carry_next;
          step_reg  <= step_reg + CW'(1);
          if (last_step) begin
            // The last step holds bit WIDTH-1, so overflow is decided here.
            result_reg    <= acc_next;
            cout_reg      <= carry_next;
            zero_reg      <= (acc_next == '0);
            neg_reg       <= acc_next[WIDTH-1];
            ovf_reg       <= msb_carry_in ^ carry_next;
            state_reg     <= DONE;
            out_valid_reg <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_reg     <= IDLE;
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
          end
        end
        default: begin
          state_reg     <= IDLE;
          out_valid_reg <= 1'b0;
          in_ready_reg  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign result    = result_reg;
  assign cout      = cout_reg;
  assign zero      = zero_reg;
  assign neg       = neg_reg;
  assign ovf       = ovf_reg;

endmodule
